meter_time_sequencer: RTL and testbench

Owns the parking meter's remaining-time register and sequences every update to it. It arbitrates between button add-requests, preset switches and the 1 Hz decrement tick so that at most one update is applied per cycle and no request is lost. After each change it runs an iterative binary-to-BCD conversion and publishes four BCD digits plus status flags to the display controller. It sits between the input conditioning logic and the display path, inside the meter top level.

---
 rtl/meter_time_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_meter_time_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/meter_time_sequencer.sv
// meter_time_sequencer
// Owns the parking meter's remaining-time register. It arbitrates button add
// requests, preset switch loads and the 1 Hz decrement so that one update is
// applied per cycle and no request is lost. After each change it converts the
// binary value to BCD with an iterative double-dabble engine and publishes
// the digits and status flags to the display controller.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   tick_1hz   one-cycle pulse per second, requests a decrement
//   u,l,r,d    debounced button levels, rising edge requests an add
//   sw0,sw1    preset switch levels, rising edge loads PRESET0/PRESET1
//   curr_time  four BCD digits, thousands in [15:12]
//   bcd_valid  one-cycle pulse when curr_time and flags update
//   below200   published value < 200
//   isZero     published value == 0
//   busy       conversion engine active (load through DONE)
module meter_time_sequencer #(
   parameter int unsigned MAX_TIME = 9999,
   parameter int unsigned ADD_U    = 10,
   parameter int unsigned ADD_L    = 180,
   parameter int unsigned ADD_R    = 200,
   parameter int unsigned ADD_D    = 550,
   parameter int unsigned PRESET0  = 10,
   parameter int unsigned PRESET1  = 205
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_1hz,
   input  logic        u,
   input  logic        l,
   input  logic        r,
   input  logic        d,
   input  logic        sw0,
   input  logic        sw1,
   output logic [15:0] curr_time,
   output logic        bcd_valid,
   output logic        below200,
   output logic        isZero,
   output logic        busy
);

   localparam logic [13:0] MAXT = 14'(MAX_TIME);
   localparam logic [13:0] AU   = 14'(ADD_U);
   localparam logic [13:0] AL   = 14'(ADD_L);
   localparam logic [13:0] AR   = 14'(ADD_R);
   localparam logic [13:0] AD   = 14'(ADD_D);
   localparam logic [13:0] P0   = 14'(PRESET0);
   localparam logic [13:0] P1   = 14'(PRESET1);

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

   function automatic logic [13:0] sat_add(input logic [13:0] t, input logic [13:0] a);
      logic [14:0] s;
      s = {1'b0, t} + {1'b0, a};
      if (s > {1'b0, MAXT}) return MAXT;
      return s[13:0];
   endfunction

   // One double-dabble iteration over {bcd accumulator, binary shifter}.
   function automatic logic [29:0] dabble_step(input logic [15:0] acc, input logic [13:0] sh);
      logic [15:0] a;
      logic [29:0] v;
      a = acc;
      for (int i = 0; i < 4; i++) begin
         if (a[i*4 +: 4] >= 4'd5) a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
      end
      v = {a, sh} << 1;
      return v;
   endfunction

   // Request bit order: [5]=sw1 [4]=sw0 [3]=u [2]=l [1]=r [0]=d
   logic [5:0]  w_lvl;
   logic [5:0]  w_rise;
   logic [5:0]  w_serve;
   logic        w_serve_tick;
   logic        w_preset;
   logic        w_act;
   logic [13:0] w_next_time;
   logic [29:0] w_dab;

   logic [5:0]  r_prev;
   logic [5:0]  r_pend;
   logic        r_tick_pend;
   logic        r_dirty;
   logic [13:0] r_time;
   state_t      r_state;
   logic [13:0] r_shift;
   logic [15:0] r_acc;
   logic [3:0]  r_cnt;
   logic        r_snap_b200;
   logic        r_snap_zero;
   logic [15:0] r_curr_time;
   logic        r_bcd_valid;
   logic        r_below200;
   logic        r_is_zero;
   logic        r_busy;

   assign w_lvl    = {sw1, sw0, u, l, r, d};
   assign w_rise   = w_lvl & ~r_prev;
   assign w_preset = w_serve[5] | w_serve[4];
   assign w_act    = (|w_serve) | w_serve_tick;
   assign w_dab    = dabble_step(r_acc, r_shift);

   // Fixed-priority arbiter: one served request per cycle.
   always_comb begin
      w_serve      = '0;
      w_serve_tick = 1'b0;
      w_next_time  = r_time;
      if (r_pend[5]) begin
         w_serve[5]  = 1'b1;
         w_next_time = P1;
      end else if (r_pend[4]) begin
         w_serve[4]  = 1'b1;
         w_next_time = P0;
      end else if (r_pend[3]) begin
         w_serve[3]  = 1'b1;
         w_next_time = sat_add(r_time, AU);
      end else if (r_pend[2]) begin
         w_serve[2]  = 1'b1;
         w_next_time = sat_add(r_time, AL);
      end else if (r_pend[1]) begin
         w_serve[1]  = 1'b1;
         w_next_time = sat_add(r_time, AR);
      end else if (r_pend[0]) begin
         w_serve[0]  = 1'b1;
         w_next_time = sat_add(r_time, AD);
      end else if (r_tick_pend) begin
         w_serve_tick = 1'b1;
         w_next_time  = (r_time == 14'd0) ? 14'd0 : r_time - 14'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev      <= w_lvl;
         r_pend      <= '0;
         r_tick_pend <= 1'b0;
         r_dirty     <= 1'b0;
         r_time      <= '0;
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_snap_b200 <= 1'b1;
         r_snap_zero <= 1'b1;
         r_curr_time <= 16'h0000;
         r_bcd_valid <= 1'b0;
         r_below200  <= 1'b1;
         r_is_zero   <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         r_prev <= w_lvl;
         // An edge on an already-pending request is dropped; a preset wipes
         // outstanding button and tick requests.
         r_pend      <= (r_pend & ~w_serve & (w_preset ? 6'b110000 : 6'b111111))
                        | (w_rise & ~r_pend);
         r_tick_pend <= (r_tick_pend & ~w_serve_tick & ~w_preset) | tick_1hz;
         r_time      <= w_next_time;
         r_bcd_valid <= 1'b0;

         // A same-cycle update keeps dirty set even while the FSM consumes it.
         r_dirty <= w_act | (r_dirty & ~(r_state == S_IDLE));

         case (r_state)
            S_IDLE: begin
               if (r_dirty) begin
                  r_shift     <= r_time;
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_snap_b200 <= (r_time < 14'd200);
                  r_snap_zero <= (r_time == 14'd0);
                  r_busy      <= 1'b1;
                  r_state     <= S_CONV;
               end
            end
            S_CONV: begin
               r_acc   <= w_dab[29:14];
               r_shift <= w_dab[13:0];
               r_cnt   <= r_cnt + 4'd1;
               if (r_cnt == 4'd13) r_state <= S_DONE;
            end
            S_DONE: begin
               r_curr_time <= r_acc;
               r_below200  <= r_snap_b200;
               r_is_zero   <= r_snap_zero;
               r_bcd_valid <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign curr_time = r_curr_time;
   assign bcd_valid = r_bcd_valid;
   assign below200  = r_below200;
   assign isZero    = r_is_zero;
   assign busy      = r_busy;

endmodule

// File: tb/tb_meter_time_sequencer.sv
module tb_meter_time_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick_1hz = 1'b0;
   logic        u = 1'b0, l = 1'b0, r = 1'b0, d = 1'b0;
   logic        sw0 = 1'b0, sw1 = 1'b0;
   logic [15:0] curr_time;
   logic        bcd_valid, below200, isZero, busy;

   int n_vec = 0;
   int n_err = 0;
   int pub_cnt = 0;
   logic [15:0] pubs[$];
   int m_time = 0;

   meter_time_sequencer dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
      .u(u), .l(l), .r(r), .d(d), .sw0(sw0), .sw1(sw1),
      .curr_time(curr_time), .bcd_valid(bcd_valid),
      .below200(below200), .isZero(isZero), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int to_bcd(input int v);
      return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
   endfunction

   // Every publication must be well-formed BCD with flags matching its digits.
   always @(negedge clk) begin
      if (!rst && bcd_valid) begin
         int v;
         int ok;
         logic [15:0] c;
         c = curr_time;
         ok = (c[15:12] < 10) && (c[11:8] < 10) && (c[7:4] < 10) && (c[3:0] < 10);
         v = c[15:12] * 1000 + c[11:8] * 100 + c[7:4] * 10 + c[3:0];
         pub_cnt++;
         pubs.push_back(c);
         chk("pub_digits", ok, 1);
         chk("pub_below200", below200, (v < 200) ? 1 : 0);
         chk("pub_isZero", isZero, (v == 0) ? 1 : 0);
      end
   end

   // mask bits: [6]=tick [5]=sw1 [4]=sw0 [3]=u [2]=l [1]=r [0]=d
   task automatic pulse(input logic [6:0] m);
      @(negedge clk);
      {tick_1hz, sw1, sw0, u, l, r, d} = m;
      @(negedge clk);
      {tick_1hz, sw1, sw0, u, l, r, d} = 7'd0;
   endtask

   // Reference: requests take effect in priority order as plain arithmetic.
   task automatic model_apply(input logic [6:0] m);
      int adds[4];
      adds = '{10, 180, 200, 550};
      if (m[5]) m_time = 205;
      else if (m[4]) m_time = 10;
      else begin
         for (int i = 0; i < 4; i++)
            if (m[3 - i]) m_time = (m_time + adds[i] > 9999) ? 9999 : m_time + adds[i];
         if (m[6] && m_time > 0) m_time = m_time - 1;
      end
   endtask

   task automatic act(input logic [6:0] m);
      pulse(m);
      model_apply(m);
   endtask

   task automatic settle();
      repeat (60) @(negedge clk);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_time"}, curr_time, to_bcd(m_time));
      chk({tag, "_b200"}, below200, (m_time < 200) ? 1 : 0);
      chk({tag, "_zero"}, isZero, (m_time == 0) ? 1 : 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_time = 0;
      pub_cnt = 0;
      pubs.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int found;
      int c0;
      logic [6:0] ma, mb;

      // Button held through reset must not fire.
      u = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_curr_time", curr_time, 16'h0000);
      chk("rst_isZero", isZero, 1);
      chk("rst_below200", below200, 1);
      chk("rst_busy", busy, 0);
      chk("rst_bcd_valid", bcd_valid, 0);
      repeat (5) @(negedge clk);
      u = 1'b0;
      repeat (100) @(negedge clk);
      chk("held_no_pub", pub_cnt, 0);
      check_state("held");

      // sw1 load with latency measurement, then ticks down past 200.
      do_reset();
      @(negedge clk);
      sw1 = 1'b1;
      @(posedge clk);
      n = 0;
      found = 0;
      while (!found && n < 40) begin
         @(posedge clk);
         n++;
         #1;
         if (bcd_valid) found = 1;
      end
      chk("sw1_latency", n, 17);
      chk("sw1_value", curr_time, 16'h0205);
      @(negedge clk);
      sw1 = 1'b0;
      m_time = 205;
      settle();
      for (int i = 0; i < 7; i++) begin
         act(7'b1000000);
         repeat (30) @(negedge clk);
         check_state("tick_down");
      end

      // Four simultaneous presses serialize: first publication is 10.
      do_reset();
      act(7'b0001111);
      settle();
      chk("four_pub_cnt", pub_cnt, 2);
      if (pubs.size() >= 2) begin
         chk("four_first", pubs[0], 16'h0010);
         chk("four_second", pubs[1], 16'h0940);
      end else chk("four_pubs_seen", pubs.size(), 2);
      check_state("four");

      // Saturation at 9999.
      do_reset();
      for (int i = 0; i < 18; i++) begin
         act(7'b0000001);
         repeat (6) @(negedge clk);
      end
      settle();
      check_state("sat_9900");
      act(7'b0000001);
      settle();
      check_state("sat_d");
      act(7'b0001000);
      settle();
      check_state("sat_u");

      // Decrement floor at zero still publishes.
      do_reset();
      act(7'b0010000);
      settle();
      for (int i = 0; i < 9; i++) begin
         act(7'b1000000);
         repeat (30) @(negedge clk);
      end
      check_state("at_one");
      act(7'b1000000);
      repeat (30) @(negedge clk);
      check_state("to_zero");
      c0 = pub_cnt;
      act(7'b1000000);
      repeat (30) @(negedge clk);
      chk("zero_tick_pub", pub_cnt, c0 + 1);
      check_state("stay_zero");

      // Press during conversion: old value then follow-up conversion.
      do_reset();
      act(7'b0100000);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (busy) found = 1;
      end
      chk("busy_seen", found, 1);
      repeat (3) @(negedge clk);
      act(7'b0001000);
      settle();
      chk("conv_pub_cnt", pub_cnt, 2);
      if (pubs.size() >= 2) begin
         chk("conv_first", pubs[0], 16'h0205);
         chk("conv_second", pubs[1], 16'h0215);
      end else chk("conv_pubs_seen", pubs.size(), 2);
      check_state("conv");

      // Randomized episodes against the reference.
      do_reset();
      for (int e = 0; e < 40; e++) begin
         for (int k = 0; k < 2; k++) begin
            case ($urandom_range(0, 7))
               0: ma = 7'b0010000;
               1: ma = 7'b0100000;
               2: ma = 7'b1000000;
               default: ma = {($urandom_range(0, 1) == 1), 2'b00, 4'($urandom_range(1, 15))};
            endcase
            if (k == 0) mb = ma;
         end
         act(mb);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(6, 20)) @(negedge clk);
            act(ma);
         end
         settle();
         check_state("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
